fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Producer end of the EX-stage forwarding interface. Decides, while an instruction sits in ID, where
//  each EX operand and the store data will come from, and registers those selects so they line up
//  with the instruction's EX cycle. Detects load-use hazards and stalls IF/ID for one cycle, with a
//  bubble into ID/EX. Sits between decode and the ID/EX register; counts stalls for performance.
// PARAMETERS
//  REG_W   3   register-address width (r0 hardwired zero, never forwarded)
//  CNT_W   16  width of saturating stall counter
// PORTS
//  clk              in   1      clock, rising edge
//  rst              in   1      reset, asynchronous, active-high
//  hold             in   1      global pipeline freeze (e.g. memory busy)
//  flush            in   1      kill instruction in ID (taken branch)
//  id_valid         in   1      ID holds a real instruction
//  id_src1/id_src2  in   REG_W  ALU operand source registers
//  id_src1_used     in   1      op1 reads a register (0 = immediate/none)
//  id_src2_used     in   1      op2 reads a register
//  id_src_st        in   REG_W  store-data source register
//  id_st_used       in   1      instruction is a store
//  id_ex_op_dest    in   REG_W  dest of instr currently in EX (ID/EX reg)
//  id_ex_wb_en      in   1      that instr writes back
//  id_ex_wb_mux     in   1      1 = that instr is a load (wb from memory)
//  ex_op_dest       in   REG_W  dest of instr in EX/MEM reg
//  ex_wb_en         in   1      that instr writes back
//  frwd_op1_mux     out  2      op1 select: 00 reg file, 10 EX result, 11 MEM result
//  frwd_op2_mux     out  2      op2 select, same coding
//  frwd_store_data  out  2      store-data select, same coding
//  stall            out  1      freeze PC and IF/ID, zero ID/EX controls (combinational)
//  stall_count      out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  - Reset: all three selects 2'b00, stall_count 0. stall is 0 while rst is asserted.
//  - match_ex(s)  = used & s!=0 & id_ex_wb_en & s==id_ex_op_dest   (producer one ahead).
//    match_mem(s) = used & s!=0 & ex_wb_en & s==ex_op_dest         (producer two ahead).
//  - Select computed in ID and registered at the next edge:
//    * match_ex and not a load -> 10.
//    * else match_mem -> 11.
//    * else 00. The younger producer has priority when both match.
//  - Load-use: lu = id_valid & ~flush & ~hold & id_ex_wb_mux & match_ex(any used source).
//    stall = lu, 1-cycle latency budget: one bubble only.
//  - Stall cycle:
//    * All registered selects load 00, because the bubble enters EX.
//    * Next cycle the same ID instr re-evaluates. The load is now in EX/MEM, so the select is 11.
//  - flush: selects load 00, stall forced 0. flush beats lu when both are asserted.
//  - id_valid=0: selects load 00.
//  - hold: all registers and the counter keep their value; stall forced 0.
//  - Register-file write/read in the same cycle (producer three ahead) is bypassed inside the
//    register file, not here.
//  - stall_count increments by 1 on every clk edge where stall=1, and saturates at all-ones.
//  - Sources are evaluated independently; op1, op2 and store may take different selects in the
//    same cycle.
//  - Select code 01 is never driven.
//  - rst asserted mid-stall: everything clears immediately. The ID instr is re-evaluated after
//    release.
// TESTING
//  - ADD r1 then ADD r2,r1,r3 back-to-back
//    -> frwd_op1_mux=10 in the consumer's EX cycle, stall never asserted.
//  - ADD r1, NOP, SUB r4,r5,r1 -> frwd_op2_mux=11, frwd_op1_mux=00.
//  - LW r2 then ADD r3,r2,r2
//    -> stall=1 for exactly 1 cycle, bubble selects 00, then op1=op2=11. stall_count=1.
//  - ADD r1, ADD r1, ST r1 -> frwd_store_data=10 (younger wins).
//    Writes to r0 or with wb_en=0 -> all 00.
//  - Load-use with flush=1 in same cycle -> stall=0, selects 00.
//    Load-use with hold=1 -> stall=0, outputs hold.
//  - Force 2^CNT_W+3 load-use stalls -> stall_count saturates at 16'hFFFF.
//    Async rst mid-stall -> immediate 0s.

Source files
------------

// File: rtl/fwd_hazard_if.sv
// Bundle between decode/pipeline control and the EX-stage forwarding/hazard unit.
// The hazard unit drives selects and stall through "master"; the pipeline side uses "slave".
interface fwd_hazard_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_src1_used;
  logic             id_src2_used;
  logic [REG_W-1:0] id_src_st;
  logic             id_st_used;
  logic [REG_W-1:0] id_ex_op_dest;
  logic             id_ex_wb_en;
  logic             id_ex_wb_mux;
  logic [REG_W-1:0] ex_op_dest;
  logic             ex_wb_en;
  logic [1:0]       frwd_op1_mux;
  logic [1:0]       frwd_op2_mux;
  logic [1:0]       frwd_store_data;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    input  hold, flush, id_valid,
    input  id_src1, id_src2, id_src1_used, id_src2_used, id_src_st, id_st_used,
    input  id_ex_op_dest, id_ex_wb_en, id_ex_wb_mux, ex_op_dest, ex_wb_en,
    output frwd_op1_mux, frwd_op2_mux, frwd_store_data, stall, stall_count
  );

  modport slave (
    output hold, flush, id_valid,
    output id_src1, id_src2, id_src1_used, id_src2_used, id_src_st, id_st_used,
    output id_ex_op_dest, id_ex_wb_en, id_ex_wb_mux, ex_op_dest, ex_wb_en,
    input  frwd_op1_mux, frwd_op2_mux, frwd_store_data, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Picks forwarding sources for the ID instruction, registers them into its EX cycle,
// and stalls IF/ID for one cycle on a load-use hazard.
module fwd_hazard_unit #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  fwd_hazard_if.master bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b10;
  localparam logic [1:0] SEL_MEM = 2'b11;

  function automatic logic match(input logic used, input logic [REG_W-1:0] src,
                                 input logic [REG_W-1:0] dest, input logic wb_en);
    return used && (src != '0) && wb_en && (src == dest);
  endfunction

  logic       ex1, ex2, exs;
  logic       mem1, mem2, mems;
  logic       lu;
  logic [1:0] op1_d, op2_d, st_d;
  logic [1:0] op1_q, op2_q, st_q;
  logic [CNT_W-1:0] stall_count_q;

  assign ex1  = match(bus.id_src1_used, bus.id_src1,   bus.id_ex_op_dest, bus.id_ex_wb_en);
  assign ex2  = match(bus.id_src2_used, bus.id_src2,   bus.id_ex_op_dest, bus.id_ex_wb_en);
  assign exs  = match(bus.id_st_used,   bus.id_src_st, bus.id_ex_op_dest, bus.id_ex_wb_en);
  assign mem1 = match(bus.id_src1_used, bus.id_src1,   bus.ex_op_dest,    bus.ex_wb_en);
  assign mem2 = match(bus.id_src2_used, bus.id_src2,   bus.ex_op_dest,    bus.ex_wb_en);
  assign mems = match(bus.id_st_used,   bus.id_src_st, bus.ex_op_dest,    bus.ex_wb_en);

  assign lu = bus.id_valid && !bus.flush && !bus.hold && bus.id_ex_wb_mux && (ex1 || ex2 || exs);

  // A load's value is not ready in EX, so a load in EX never forwards; lu covers that case.
  always_comb begin
    op1_d = SEL_RF;
    op2_d = SEL_RF;
    st_d  = SEL_RF;
    if (bus.id_valid && !bus.flush && !lu) begin
      op1_d = (ex1 && !bus.id_ex_wb_mux) ? SEL_EX : (mem1 ? SEL_MEM : SEL_RF);
      op2_d = (ex2 && !bus.id_ex_wb_mux) ? SEL_EX : (mem2 ? SEL_MEM : SEL_RF);
      st_d  = (exs && !bus.id_ex_wb_mux) ? SEL_EX : (mems ? SEL_MEM : SEL_RF);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q         <= SEL_RF;
      op2_q         <= SEL_RF;
      st_q          <= SEL_RF;
      stall_count_q <= '0;
    end else if (!bus.hold) begin
      op1_q <= op1_d;
      op2_q <= op2_d;
      st_q  <= st_d;
      if (lu && (stall_count_q != '1))
        stall_count_q <= stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.frwd_op1_mux    = op1_q;
  assign bus.frwd_op2_mux    = op2_q;
  assign bus.frwd_store_data = st_q;
  assign bus.stall           = lu && !rst;
  assign bus.stall_count     = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding selects, load-use stall, flush/hold,
// counter saturation and asynchronous reset.
module tb_fwd_hazard_unit;
  localparam int REG_W = 3;
  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fwd_hazard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic clear_id();
    bus.hold = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_src1 = 0; bus.id_src2 = 0; bus.id_src1_used = 0; bus.id_src2_used = 0;
    bus.id_src_st = 0; bus.id_st_used = 0;
    bus.id_ex_op_dest = 0; bus.id_ex_wb_en = 0; bus.id_ex_wb_mux = 0;
    bus.ex_op_dest = 0; bus.ex_wb_en = 0;
  endtask

  task automatic set_id(input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                        input logic u2, input logic [2:0] st, input logic ust);
    bus.id_valid = 1;
    bus.id_src1 = s1; bus.id_src1_used = u1;
    bus.id_src2 = s2; bus.id_src2_used = u2;
    bus.id_src_st = st; bus.id_st_used = ust;
  endtask

  task automatic set_prod(input logic [2:0] exd, input logic exen, input logic ld,
                          input logic [2:0] memd, input logic memen);
    bus.id_ex_op_dest = exd; bus.id_ex_wb_en = exen; bus.id_ex_wb_mux = ld;
    bus.ex_op_dest = memd; bus.ex_wb_en = memen;
  endtask

  // advance past the next rising edge, sampling point is 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sel(input string tag, input logic [1:0] e1, input logic [1:0] e2,
                           input logic [1:0] es);
    check({tag, "_op1"}, 32'(bus.frwd_op1_mux), 32'(e1));
    check({tag, "_op2"}, 32'(bus.frwd_op2_mux), 32'(e2));
    check({tag, "_st"},  32'(bus.frwd_store_data), 32'(es));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_id();
    rst = 1;

    // reset: load-use inputs present, stall must still be 0
    set_prod(3'd2, 1, 1, 3'd0, 0);
    set_id(3'd2, 1, 3'd0, 0, 3'd0, 0);
    repeat (2) tick();
    check_sel("reset", 2'b00, 2'b00, 2'b00);
    check("reset_stall", 32'(bus.stall), 32'd0);
    check("reset_count", 32'(bus.stall_count), 32'd0);
    clear_id();
    rst = 0;
    tick();

    // ADD r1 ; ADD r2,r1,r3 -> op1 from EX
    set_prod(3'd1, 1, 0, 3'd0, 0);
    set_id(3'd1, 1, 3'd3, 1, 3'd0, 0);
    #1 check("exfwd_stall", 32'(bus.stall), 32'd0);
    tick();
    check_sel("exfwd", 2'b10, 2'b00, 2'b00);

    // ADD r1 ; NOP ; SUB r4,r5,r1 -> op2 from MEM
    set_prod(3'd0, 0, 0, 3'd1, 1);
    set_id(3'd5, 1, 3'd1, 1, 3'd0, 0);
    tick();
    check_sel("memfwd", 2'b00, 2'b11, 2'b00);

    // LW r2 ; ADD r3,r2,r2 -> one stall, bubble, then both from MEM
    set_prod(3'd2, 1, 1, 3'd0, 0);
    set_id(3'd2, 1, 3'd2, 1, 3'd0, 0);
    #1 check("lu_stall", 32'(bus.stall), 32'd1);
    tick();
    check_sel("lu_bubble", 2'b00, 2'b00, 2'b00);
    check("lu_count", 32'(bus.stall_count), 32'd1);
    set_prod(3'd0, 0, 0, 3'd2, 1);
    #1 check("lu_restall", 32'(bus.stall), 32'd0);
    tick();
    check_sel("lu_after", 2'b11, 2'b11, 2'b00);
    check("lu_count2", 32'(bus.stall_count), 32'd1);

    // ADD r1 ; ADD r1 ; ST r1 -> younger producer wins
    set_prod(3'd1, 1, 0, 3'd1, 1);
    set_id(3'd0, 0, 3'd0, 0, 3'd1, 1);
    tick();
    check_sel("younger", 2'b00, 2'b00, 2'b10);

    // independent sources: store from EX, op1 from MEM, op2 from regfile
    set_prod(3'd1, 1, 0, 3'd3, 1);
    set_id(3'd3, 1, 3'd2, 1, 3'd1, 1);
    tick();
    check_sel("indep", 2'b11, 2'b00, 2'b10);

    // r0 is never forwarded
    set_prod(3'd0, 1, 0, 3'd0, 1);
    set_id(3'd0, 1, 3'd0, 1, 3'd0, 1);
    tick();
    check_sel("r0", 2'b00, 2'b00, 2'b00);

    // matching dest but no write-back
    set_prod(3'd4, 0, 0, 3'd5, 0);
    set_id(3'd4, 1, 3'd5, 1, 3'd4, 1);
    tick();
    check_sel("nowb", 2'b00, 2'b00, 2'b00);

    // flush beats load-use; selects cleared from a non-zero state
    set_prod(3'd1, 1, 0, 3'd0, 0);
    set_id(3'd1, 1, 3'd1, 1, 3'd1, 1);
    tick();
    check_sel("preflush", 2'b10, 2'b10, 2'b10);
    set_prod(3'd1, 1, 1, 3'd0, 0);
    bus.flush = 1;
    #1 check("flush_stall", 32'(bus.stall), 32'd0);
    tick();
    check_sel("flush", 2'b00, 2'b00, 2'b00);
    check("flush_count", 32'(bus.stall_count), 32'd1);
    bus.flush = 0;

    // id_valid low with forwarding matches present
    set_prod(3'd1, 1, 0, 3'd2, 1);
    set_id(3'd1, 1, 3'd2, 1, 3'd1, 1);
    tick();
    check_sel("prevalid", 2'b10, 2'b11, 2'b10);
    bus.id_valid = 0;
    tick();
    check_sel("novalid", 2'b00, 2'b00, 2'b00);

    // hold: load-use suppressed, registers keep value
    set_prod(3'd1, 1, 0, 3'd2, 1);
    set_id(3'd2, 1, 3'd1, 1, 3'd2, 1);
    tick();
    check_sel("prehold", 2'b11, 2'b10, 2'b11);
    set_prod(3'd1, 1, 1, 3'd0, 0);
    set_id(3'd1, 1, 3'd0, 0, 3'd0, 0);
    bus.hold = 1;
    #1 check("hold_stall", 32'(bus.stall), 32'd0);
    repeat (2) tick();
    check_sel("hold", 2'b11, 2'b10, 2'b11);
    check("hold_count", 32'(bus.stall_count), 32'd1);
    bus.hold = 0;

    // saturation: 2^16+3 consecutive load-use stalls starting from count 1
    set_prod(3'd3, 1, 1, 3'd0, 0);
    set_id(3'd3, 1, 3'd0, 0, 3'd0, 0);
    repeat (65533) tick();
    check("sat_near", 32'(bus.stall_count), 32'hFFFE);
    repeat (6) tick();
    check("sat_full", 32'(bus.stall_count), 32'hFFFF);
    check("sat_stall", 32'(bus.stall), 32'd1);

    // asynchronous reset in the middle of a stall cycle
    @(negedge clk);
    rst = 1;
    #1;
    check("arst_stall", 32'(bus.stall), 32'd0);
    check("arst_count", 32'(bus.stall_count), 32'd0);
    check_sel("arst", 2'b00, 2'b00, 2'b00);
    tick();
    rst = 0;
    #1 check("arst_reeval", 32'(bus.stall), 32'd1);
    tick();
    check("arst_count2", 32'(bus.stall_count), 32'd1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
